// File: rtl/wb_pkg_ysyx_23060136.sv
// Shared types for the write-back retire queue: buffered entry layout and FSM states.
package wb_pkg_ysyx_23060136;

    localparam int unsigned WB_XLEN   = 32;
    localparam int unsigned WB_GPR_AW = 5;
    localparam int unsigned WB_CSR_AW = 3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_e;

    // One retire slot; busW is already resolved at enqueue time.
    typedef struct packed {
        logic [WB_XLEN-1:0]   pc;
        logic [WB_XLEN-1:0]   inst;
        logic [WB_XLEN-1:0]   busw;
        logic [WB_XLEN-1:0]   csr_busw;
        logic [WB_GPR_AW-1:0] rd;
        logic [WB_CSR_AW-1:0] csr_rd;
        logic                 write_gpr;
        logic                 write_csr;
        logic                 system_halt;
    } wb_entry_t;

    function automatic logic [WB_XLEN-1:0] wb_sel_busw(
        input logic               mem_to_reg,
        input logic [WB_XLEN-1:0] rdata,
        input logic [WB_XLEN-1:0] aluout
    );
        return mem_to_reg ? rdata : aluout;
    endfunction

endpackage

// File: rtl/wb_buf_ysyx_23060136.sv
// Circular entry store for the retire queue; exposes all slots in age order (index 0 = head).
module wb_buf_ysyx_23060136
    import wb_pkg_ysyx_23060136::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  wb_entry_t                  push_entry,
    output wb_entry_t                  age_entry [DEPTH],
    output logic [DEPTH-1:0]           age_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t         slot_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot_q[tail_q] <= push_entry;
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            age_entry[i] = slot_q[head_q + PW'(i)];
            age_valid[i] = CW'(i) < count_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_retire_queue_ysyx_23060136.sv
// Write-back retire queue: buffers completed instructions, retires them in order into the
// register files, forwards pending results and stops retiring after a halt instruction.
module wb_retire_queue_ysyx_23060136
    import wb_pkg_ysyx_23060136::*;
#(
    parameter int unsigned XLEN   = WB_XLEN,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GPR_AW = WB_GPR_AW,
    parameter int unsigned CSR_AW = WB_CSR_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      WB_i_valid,
    output logic                      WB_o_ready,
    input  logic [XLEN-1:0]           WB_i_pc,
    input  logic [XLEN-1:0]           WB_i_inst,
    input  logic [XLEN-1:0]           WB_i_ALU_ALUout,
    input  logic [XLEN-1:0]           WB_i_ALU_CSR_out,
    input  logic [XLEN-1:0]           WB_i_rdata,
    input  logic [GPR_AW-1:0]         WB_i_rd,
    input  logic [CSR_AW-1:0]         WB_i_csr_rd,
    input  logic                      WB_i_write_gpr,
    input  logic                      WB_i_write_csr,
    input  logic                      WB_i_mem_to_reg,
    input  logic                      WB_i_system_halt,
    input  logic                      WB_i_rf_ready,
    output logic [XLEN-1:0]           WB_o_rf_busW,
    output logic [GPR_AW-1:0]         WB_o_rd,
    output logic                      WB_o_RegWr,
    output logic [XLEN-1:0]           WB_o_csr_busW,
    output logic [CSR_AW-1:0]         WB_o_csr_rd,
    output logic                      WB_o_CSRWr,
    output logic                      WB_o_commit,
    output logic [XLEN-1:0]           WB_o_pc,
    output logic [XLEN-1:0]           WB_o_inst,
    output logic                      WB_o_system_halt,
    input  logic [GPR_AW-1:0]         WB_i_rs1_addr,
    input  logic [GPR_AW-1:0]         WB_i_rs2_addr,
    input  logic [CSR_AW-1:0]         WB_i_csr_rs_addr,
    output logic                      WB_o_rs1_hit,
    output logic                      WB_o_rs2_hit,
    output logic                      WB_o_csr_hit,
    output logic [XLEN-1:0]           WB_o_rs1_data,
    output logic [XLEN-1:0]           WB_o_rs2_data,
    output logic [XLEN-1:0]           WB_o_csr_rs_data,
    output logic [$clog2(DEPTH):0]    WB_o_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_state_e         state_q, state_d;
    logic              out_en_q, out_en_d;
    logic              live, run, ready, accept, retire;
    wb_entry_t         in_entry, head;
    wb_entry_t         age_entry [DEPTH];
    logic [DEPTH-1:0]  age_valid;
    logic [CW-1:0]     count;

    always_comb begin
        in_entry             = '0;
        in_entry.pc          = WB_i_pc;
        in_entry.inst        = WB_i_inst;
        in_entry.busw        = wb_sel_busw(WB_i_mem_to_reg, WB_i_rdata, WB_i_ALU_ALUout);
        in_entry.csr_busw    = WB_i_ALU_CSR_out;
        in_entry.rd          = WB_i_rd;
        in_entry.csr_rd      = WB_i_csr_rd;
        in_entry.write_gpr   = WB_i_write_gpr;
        in_entry.write_csr   = WB_i_write_csr;
        in_entry.system_halt = WB_i_system_halt;
    end

    wb_buf_ysyx_23060136 #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .pop        (retire),
        .push_entry (in_entry),
        .age_entry  (age_entry),
        .age_valid  (age_valid),
        .count      (count)
    );

    assign head = age_entry[0];

    // out_en_q stays low for the cycle after reset so every output is quiet there too.
    always_comb begin
        state_d  = state_q;
        out_en_d = 1'b1;
        live     = out_en_q && !rst;
        run      = live && (state_q == ST_RUN);
        ready    = run && (count < CW'(DEPTH));
        accept   = WB_i_valid && ready;
        retire   = run && (count != '0) && WB_i_rf_ready;
        if (retire && head.system_halt) state_d = ST_HALTED;

        WB_o_ready       = ready;
        WB_o_commit      = retire;
        WB_o_pc          = retire ? head.pc       : '0;
        WB_o_inst        = retire ? head.inst     : '0;
        WB_o_rf_busW     = retire ? head.busw     : '0;
        WB_o_rd          = retire ? head.rd       : '0;
        WB_o_RegWr       = retire && head.write_gpr && (head.rd != '0);
        WB_o_csr_busW    = retire ? head.csr_busw : '0;
        WB_o_csr_rd      = retire ? head.csr_rd   : '0;
        WB_o_CSRWr       = retire && head.write_csr;
        WB_o_system_halt = live && ((state_q == ST_HALTED) || (retire && head.system_halt));
        WB_o_count       = live ? count : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_en_q <= out_en_d;
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        WB_o_rs1_hit     = 1'b0;
        WB_o_rs2_hit     = 1'b0;
        WB_o_csr_hit     = 1'b0;
        WB_o_rs1_data    = '0;
        WB_o_rs2_data    = '0;
        WB_o_csr_rs_data = '0;
        if (live) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (age_valid[i] && age_entry[i].write_gpr && (WB_i_rs1_addr != '0)
                    && (age_entry[i].rd == WB_i_rs1_addr)) begin
                    WB_o_rs1_hit  = 1'b1;
                    WB_o_rs1_data = age_entry[i].busw;
                end
                if (age_valid[i] && age_entry[i].write_gpr && (WB_i_rs2_addr != '0)
                    && (age_entry[i].rd == WB_i_rs2_addr)) begin
                    WB_o_rs2_hit  = 1'b1;
                    WB_o_rs2_data = age_entry[i].busw;
                end
                if (age_valid[i] && age_entry[i].write_csr
                    && (age_entry[i].csr_rd == WB_i_csr_rs_addr)) begin
                    WB_o_csr_hit     = 1'b1;
                    WB_o_csr_rs_data = age_entry[i].csr_busw;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_queue_ysyx_23060136.sv
// Directed bench for the write-back retire queue with hand-computed expectations.
module tb_wb_retire_queue_ysyx_23060136;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_i_valid;
    logic        WB_o_ready;
    logic [31:0] WB_i_pc, WB_i_inst, WB_i_ALU_ALUout, WB_i_ALU_CSR_out, WB_i_rdata;
    logic [4:0]  WB_i_rd;
    logic [2:0]  WB_i_csr_rd;
    logic        WB_i_write_gpr, WB_i_write_csr, WB_i_mem_to_reg, WB_i_system_halt;
    logic        WB_i_rf_ready;
    logic [31:0] WB_o_rf_busW;
    logic [4:0]  WB_o_rd;
    logic        WB_o_RegWr;
    logic [31:0] WB_o_csr_busW;
    logic [2:0]  WB_o_csr_rd;
    logic        WB_o_CSRWr;
    logic        WB_o_commit;
    logic [31:0] WB_o_pc, WB_o_inst;
    logic        WB_o_system_halt;
    logic [4:0]  WB_i_rs1_addr, WB_i_rs2_addr;
    logic [2:0]  WB_i_csr_rs_addr;
    logic        WB_o_rs1_hit, WB_o_rs2_hit, WB_o_csr_hit;
    logic [31:0] WB_o_rs1_data, WB_o_rs2_data, WB_o_csr_rs_data;
    logic [2:0]  WB_o_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_retire_queue_ysyx_23060136 #(
        .XLEN(32), .DEPTH(4), .GPR_AW(5), .CSR_AW(3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .WB_i_valid       (WB_i_valid),
        .WB_o_ready       (WB_o_ready),
        .WB_i_pc          (WB_i_pc),
        .WB_i_inst        (WB_i_inst),
        .WB_i_ALU_ALUout  (WB_i_ALU_ALUout),
        .WB_i_ALU_CSR_out (WB_i_ALU_CSR_out),
        .WB_i_rdata       (WB_i_rdata),
        .WB_i_rd          (WB_i_rd),
        .WB_i_csr_rd      (WB_i_csr_rd),
        .WB_i_write_gpr   (WB_i_write_gpr),
        .WB_i_write_csr   (WB_i_write_csr),
        .WB_i_mem_to_reg  (WB_i_mem_to_reg),
        .WB_i_system_halt (WB_i_system_halt),
        .WB_i_rf_ready    (WB_i_rf_ready),
        .WB_o_rf_busW     (WB_o_rf_busW),
        .WB_o_rd          (WB_o_rd),
        .WB_o_RegWr       (WB_o_RegWr),
        .WB_o_csr_busW    (WB_o_csr_busW),
        .WB_o_csr_rd      (WB_o_csr_rd),
        .WB_o_CSRWr       (WB_o_CSRWr),
        .WB_o_commit      (WB_o_commit),
        .WB_o_pc          (WB_o_pc),
        .WB_o_inst        (WB_o_inst),
        .WB_o_system_halt (WB_o_system_halt),
        .WB_i_rs1_addr    (WB_i_rs1_addr),
        .WB_i_rs2_addr    (WB_i_rs2_addr),
        .WB_i_csr_rs_addr (WB_i_csr_rs_addr),
        .WB_o_rs1_hit     (WB_o_rs1_hit),
        .WB_o_rs2_hit     (WB_o_rs2_hit),
        .WB_o_csr_hit     (WB_o_csr_hit),
        .WB_o_rs1_data    (WB_o_rs1_data),
        .WB_o_rs2_data    (WB_o_rs2_data),
        .WB_o_csr_rs_data (WB_o_csr_rs_data),
        .WB_o_count       (WB_o_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        WB_i_valid       = 1'b0;
        WB_i_pc          = '0;
        WB_i_inst        = '0;
        WB_i_ALU_ALUout  = '0;
        WB_i_ALU_CSR_out = '0;
        WB_i_rdata       = '0;
        WB_i_rd          = '0;
        WB_i_csr_rd      = '0;
        WB_i_write_gpr   = 1'b0;
        WB_i_write_csr   = 1'b0;
        WB_i_mem_to_reg  = 1'b0;
        WB_i_system_halt = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic m2r, input logic [4:0] rd, input logic wgpr, input logic halt);
        WB_i_valid       = 1'b1;
        WB_i_pc          = pc;
        WB_i_inst        = pc + 32'h1000_0000;
        WB_i_ALU_ALUout  = alu;
        WB_i_rdata       = rdata;
        WB_i_mem_to_reg  = m2r;
        WB_i_rd          = rd;
        WB_i_write_gpr   = wgpr;
        WB_i_system_halt = halt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_in();
        WB_i_rf_ready    = 1'b0;
        WB_i_rs1_addr    = '0;
        WB_i_rs2_addr    = '0;
        WB_i_csr_rs_addr = '0;

        // reset and the quiet cycle after it
        step(); #1;
        check("rst_ready", 64'(WB_o_ready), 64'd0);
        check("rst_count", 64'(WB_o_count), 64'd0);
        check("rst_commit", 64'(WB_o_commit), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("postrst_ready", 64'(WB_o_ready), 64'd0);
        step();

        // first accept then retire one cycle later
        drive(32'h8000_0000, 32'h11, 32'h0, 1'b0, 5'd1, 1'b1, 1'b0);
        WB_i_rf_ready = 1'b1;
        #1;
        check("t1_ready", 64'(WB_o_ready), 64'd1);
        check("t1_commit_early", 64'(WB_o_commit), 64'd0);
        step();
        WB_i_valid = 1'b0;
        #1;
        check("t1_commit", 64'(WB_o_commit), 64'd1);
        check("t1_pc", 64'(WB_o_pc), 64'h8000_0000);
        check("t1_inst", 64'(WB_o_inst), 64'h9000_0000);
        check("t1_count", 64'(WB_o_count), 64'd1);
        check("t1_halt", 64'(WB_o_system_halt), 64'd0);
        step(); #1;
        check("t1_count_back", 64'(WB_o_count), 64'd0);
        check("t1_commit_off", 64'(WB_o_commit), 64'd0);

        // load mux with x0 destination, then ALU path with CSR write
        drive(32'h10, 32'hDEAD, 32'h1234, 1'b1, 5'd0, 1'b1, 1'b0);
        step();
        WB_i_valid = 1'b0;
        #1;
        check("x0_commit", 64'(WB_o_commit), 64'd1);
        check("x0_regwr", 64'(WB_o_RegWr), 64'd0);
        check("x0_busw", 64'(WB_o_rf_busW), 64'h1234);
        step();
        drive(32'h14, 32'h5678, 32'h9999, 1'b0, 5'd3, 1'b1, 1'b0);
        WB_i_write_csr = 1'b1; WB_i_csr_rd = 3'd2; WB_i_ALU_CSR_out = 32'h55;
        step();
        idle_in();
        #1;
        check("alu_regwr", 64'(WB_o_RegWr), 64'd1);
        check("alu_rd", 64'(WB_o_rd), 64'd3);
        check("alu_busw", 64'(WB_o_rf_busW), 64'h5678);
        check("csr_wr", 64'(WB_o_CSRWr), 64'd1);
        check("csr_rd", 64'(WB_o_csr_rd), 64'd2);
        check("csr_busw", 64'(WB_o_csr_busW), 64'h55);
        step();

        // fill to DEPTH with retire blocked, then drain in order
        WB_i_rf_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h100 + 32'(4 * i), 32'(i), 32'h0, 1'b0, 5'd1, 1'b1, 1'b0);
            step();
        end
        drive(32'h999, 32'h0, 32'h0, 1'b0, 5'd1, 1'b1, 1'b0);
        #1;
        check("fill_ready", 64'(WB_o_ready), 64'd0);
        check("fill_count", 64'(WB_o_count), 64'd4);
        step();
        WB_i_valid = 1'b0;
        WB_i_rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_commit", 64'(WB_o_commit), 64'd1);
            check("drain_pc", 64'(WB_o_pc), 64'h100 + 64'(4 * i));
            check("drain_count", 64'(WB_o_count), 64'(4 - i));
            step();
        end
        #1;
        check("drain_empty", 64'(WB_o_count), 64'd0);
        check("drain_idle", 64'(WB_o_commit), 64'd0);

        // forwarding: youngest wins, incoming entry never forwards, retiring entry does
        WB_i_rf_ready = 1'b0;
        WB_i_rs1_addr = 5'd5; WB_i_rs2_addr = 5'd0; WB_i_csr_rs_addr = 3'd3;
        drive(32'h200, 32'hA, 32'h0, 1'b0, 5'd5, 1'b1, 1'b0);
        WB_i_write_csr = 1'b1; WB_i_csr_rd = 3'd3; WB_i_ALU_CSR_out = 32'h33;
        step();
        drive(32'h204, 32'hB, 32'h0, 1'b0, 5'd5, 1'b1, 1'b0);
        WB_i_write_csr = 1'b0;
        step();
        drive(32'h208, 32'hC, 32'h0, 1'b0, 5'd7, 1'b1, 1'b0);
        WB_i_rs2_addr = 5'd7;
        #1;
        check("fwd_rs1_hit", 64'(WB_o_rs1_hit), 64'd1);
        check("fwd_rs1_young", 64'(WB_o_rs1_data), 64'hB);
        check("fwd_incoming_hit", 64'(WB_o_rs2_hit), 64'd0);
        check("fwd_incoming_data", 64'(WB_o_rs2_data), 64'd0);
        check("fwd_csr_hit", 64'(WB_o_csr_hit), 64'd1);
        check("fwd_csr_data", 64'(WB_o_csr_rs_data), 64'h33);
        step();
        WB_i_valid = 1'b0;
        #1;
        check("fwd_rs2_hit", 64'(WB_o_rs2_hit), 64'd1);
        check("fwd_rs2_data", 64'(WB_o_rs2_data), 64'hC);
        WB_i_rs2_addr = 5'd0;
        #1;
        check("fwd_x0_hit", 64'(WB_o_rs2_hit), 64'd0);
        WB_i_rf_ready = 1'b1;
        #1;
        check("fwd_ret_commit", 64'(WB_o_commit), 64'd1);
        check("fwd_ret_rs1", 64'(WB_o_rs1_data), 64'hB);
        check("fwd_ret_csr", 64'(WB_o_csr_hit), 64'd1);
        step(); step(); step(); #1;
        check("fwd_gone_hit", 64'(WB_o_rs1_hit), 64'd0);
        check("fwd_gone_data", 64'(WB_o_rs1_data), 64'd0);
        check("fwd_gone_csr", 64'(WB_o_csr_hit), 64'd0);
        check("fwd_gone_count", 64'(WB_o_count), 64'd0);

        // nine back-to-back accept/retire pairs across the pointer wrap
        idle_in();
        for (int k = 0; k < 9; k++) begin
            drive(32'h400 + 32'(4 * k), 32'(k), 32'h0, 1'b0, 5'd2, 1'b1, 1'b0);
            #1;
            check("wrap_commit", 64'(WB_o_commit), 64'(k != 0));
            if (k != 0) begin
                check("wrap_pc", 64'(WB_o_pc), 64'h400 + 64'(4 * (k - 1)));
                check("wrap_count", 64'(WB_o_count), 64'd1);
            end
            step();
        end
        WB_i_valid = 1'b0;
        #1;
        check("wrap_last_pc", 64'(WB_o_pc), 64'h420);
        step(); #1;
        check("wrap_empty", 64'(WB_o_count), 64'd0);

        // hold at DEPTH-1, then reset with three entries buffered
        WB_i_rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h300 + 32'(4 * i), 32'h0, 32'h0, 1'b0, 5'd4, 1'b1, 1'b0);
            step();
        end
        drive(32'h30C, 32'h0, 32'h0, 1'b0, 5'd4, 1'b1, 1'b0);
        WB_i_rf_ready = 1'b1;
        #1;
        check("hold3_commit", 64'(WB_o_commit), 64'd1);
        check("hold3_pc", 64'(WB_o_pc), 64'h300);
        check("hold3_ready", 64'(WB_o_ready), 64'd1);
        step();
        WB_i_valid = 1'b0;
        WB_i_rf_ready = 1'b0;
        #1;
        check("hold3_count", 64'(WB_o_count), 64'd3);
        rst = 1'b1;
        WB_i_rf_ready = 1'b1;
        #1;
        check("midrst_commit", 64'(WB_o_commit), 64'd0);
        check("midrst_count", 64'(WB_o_count), 64'd0);
        check("midrst_ready", 64'(WB_o_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("afterrst_commit", 64'(WB_o_commit), 64'd0);
        check("afterrst_ready", 64'(WB_o_ready), 64'd0);
        step(); #1;
        check("flushed_commit", 64'(WB_o_commit), 64'd0);
        check("flushed_count", 64'(WB_o_count), 64'd0);
        check("flushed_ready", 64'(WB_o_ready), 64'd1);

        // halt entry followed by two more that must never retire
        WB_i_rf_ready = 1'b0;
        drive(32'h500, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
        step();
        drive(32'h504, 32'h99, 32'h0, 1'b0, 5'd9, 1'b1, 1'b0);
        step();
        drive(32'h508, 32'hAA, 32'h0, 1'b0, 5'd10, 1'b1, 1'b0);
        step();
        WB_i_valid = 1'b0;
        WB_i_rf_ready = 1'b1;
        #1;
        check("halt_commit", 64'(WB_o_commit), 64'd1);
        check("halt_pc", 64'(WB_o_pc), 64'h500);
        check("halt_flag", 64'(WB_o_system_halt), 64'd1);
        step();
        drive(32'h50C, 32'h0, 32'h0, 1'b0, 5'd11, 1'b1, 1'b0);
        WB_i_rs1_addr = 5'd9;
        #1;
        check("halted_commit", 64'(WB_o_commit), 64'd0);
        check("halted_flag", 64'(WB_o_system_halt), 64'd1);
        check("halted_ready", 64'(WB_o_ready), 64'd0);
        check("halted_count", 64'(WB_o_count), 64'd2);
        check("halted_fwd_hit", 64'(WB_o_rs1_hit), 64'd1);
        check("halted_fwd_data", 64'(WB_o_rs1_data), 64'h99);
        step(); step(); #1;
        check("halted_still", 64'(WB_o_commit), 64'd0);
        check("halted_count2", 64'(WB_o_count), 64'd2);
        check("halted_sticky", 64'(WB_o_system_halt), 64'd1);

        // reset leaves HALTED
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); #1;
        check("rerun_halt", 64'(WB_o_system_halt), 64'd0);
        check("rerun_ready", 64'(WB_o_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
